// File: rtl/minibyte_pkg.sv
// Shared definitions for the minibyte bus interface: state encoding,
// internal I/O addresses and the read data returned on a watchdog timeout.
package minibyte_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    RELEASE  = 2'd2,
    COMPLETE = 2'd3
  } busif_state_e;

  localparam logic [7:0] ADDR_PORT_OUT = 8'hFF;
  localparam logic [7:0] ADDR_PORT_IN  = 8'hFE;
  localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

  // True for the two top-of-map addresses served by the on-chip port pair.
  function automatic logic is_internal(input logic [7:0] addr);
    return (addr == ADDR_PORT_OUT) || (addr == ADDR_PORT_IN);
  endfunction

endpackage

// File: rtl/minibyte_sync2.sv
// Two-flop synchronizer for asynchronous inputs, reset to all zeros.
module minibyte_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture; the first stage is allowed to go metastable
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= async_in;
      sync_r <= meta_r;
    end
  end

  assign sync_out = sync_r;

endmodule

// File: rtl/minibyte_busif.sv
// Bus interface for the minibyte CPU: internal I/O port pair at the top of
// the map, four-phase req/ack external byte bus everywhere else, CPU stall
// through cpu_ena_out and a watchdog that force-completes hung accesses.
module minibyte_busif #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ena_in,
  input  logic [7:0] cpu_addr_in,
  input  logic [7:0] cpu_wdata_in,
  input  logic       cpu_we_in,
  output logic [7:0] cpu_rdata_out,
  output logic       cpu_ena_out,
  output logic [7:0] ext_addr_out,
  output logic [7:0] ext_data_out,
  input  logic [7:0] ext_data_in,
  output logic       ext_oe_out,
  output logic       ext_we_out,
  output logic       ext_req_out,
  input  logic       ext_ack_in,
  input  logic [7:0] port_in,
  output logic [7:0] port_out,
  output logic       err_out
);
  import minibyte_pkg::*;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 32'd1);

  busif_state_e state_r, state_next_s;
  logic         ack_s;
  logic [7:0]   port_sync_s;
  logic [7:0]   wd_cnt_r;
  logic [7:0]   rd_latch_r;
  logic [7:0]   port_out_r, ext_addr_r, ext_data_r;
  logic         ext_req_r, ext_oe_r, ext_we_r, err_r;
  logic         internal_s, start_s, on_bus_s, timeout_s;
  logic         cpu_ena_s;
  logic [7:0]   cpu_rdata_s;

  minibyte_sync2 #(.WIDTH(1)) u_ack_sync (
    .clk_in(clk_in), .rst_in(rst_in), .async_in(ext_ack_in), .sync_out(ack_s)
  );

  minibyte_sync2 #(.WIDTH(8)) u_port_sync (
    .clk_in(clk_in), .rst_in(rst_in), .async_in(port_in), .sync_out(port_sync_s)
  );

  assign internal_s = is_internal(cpu_addr_in);
  assign on_bus_s   = (state_r == REQ) || (state_r == RELEASE);
  assign timeout_s  = on_bus_s && (wd_cnt_r == TIMEOUT_LAST);
  // A stale ack left over from a timed-out access must drain before a new request
  assign start_s    = (state_r == IDLE) && !internal_s && ena_in && !ack_s;

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; the watchdog has priority over the handshake
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_next_s = REQ;
        else         state_next_s = IDLE;
      end
      REQ: begin
        if (timeout_s)  state_next_s = COMPLETE;
        else if (ack_s) state_next_s = RELEASE;
        else            state_next_s = REQ;
      end
      RELEASE: begin
        if (timeout_s || !ack_s) state_next_s = COMPLETE;
        else                     state_next_s = RELEASE;
      end
      COMPLETE: begin
        if (ena_in) state_next_s = IDLE;
        else        state_next_s = COMPLETE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // CPU-facing outputs: internal hits answer at once, external results come from rd_latch
  always_comb begin
    cpu_ena_s   = 1'b0;
    cpu_rdata_s = 8'h00;
    case (state_r)
      IDLE: begin
        if (internal_s) begin
          cpu_ena_s   = ena_in;
          cpu_rdata_s = (cpu_addr_in == ADDR_PORT_OUT) ? port_out_r : port_sync_s;
        end else begin
          cpu_ena_s   = 1'b0;
          cpu_rdata_s = 8'h00;
        end
      end
      COMPLETE: begin
        cpu_ena_s   = ena_in;
        cpu_rdata_s = rd_latch_r;
      end
      default: begin
        cpu_ena_s   = 1'b0;
        cpu_rdata_s = 8'h00;
      end
    endcase
  end

  // Watchdog counts only while the external handshake is in progress
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wd_cnt_r <= 8'h00;
    end else if (on_bus_s) begin
      wd_cnt_r <= wd_cnt_r + 8'd1;
    end else begin
      wd_cnt_r <= 8'h00;
    end
  end

  // External bus registers: latch the access on start, hold req/oe through REQ
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ext_addr_r <= 8'h00;
      ext_data_r <= 8'h00;
      ext_we_r   <= 1'b0;
      ext_req_r  <= 1'b0;
      ext_oe_r   <= 1'b0;
    end else if (start_s) begin
      ext_addr_r <= cpu_addr_in;
      ext_data_r <= cpu_wdata_in;
      ext_we_r   <= cpu_we_in;
      ext_req_r  <= 1'b1;
      ext_oe_r   <= cpu_we_in;
    end else if (state_next_s != REQ) begin
      ext_req_r  <= 1'b0;
      ext_oe_r   <= 1'b0;
    end
  end

  // Read capture on ack, forced timeout data and the sticky error flag
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_latch_r <= 8'h00;
      err_r      <= 1'b0;
    end else if (timeout_s) begin
      rd_latch_r <= TIMEOUT_RDATA;
      err_r      <= 1'b1;
    end else if ((state_r == REQ) && ack_s && !ext_we_r) begin
      rd_latch_r <= ext_data_in;
    end
  end

  // Output port register, written by the CPU in the cycle it is not stalled
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      port_out_r <= 8'h00;
    end else if ((state_r == IDLE) && (cpu_addr_in == ADDR_PORT_OUT) && cpu_we_in && ena_in) begin
      port_out_r <= cpu_wdata_in;
    end
  end

  assign cpu_ena_out   = cpu_ena_s & rst_in;
  assign cpu_rdata_out = cpu_rdata_s;
  assign ext_addr_out  = ext_addr_r;
  assign ext_data_out  = ext_data_r;
  assign ext_we_out    = ext_we_r;
  assign ext_req_out   = ext_req_r;
  assign ext_oe_out    = ext_oe_r;
  assign port_out      = port_out_r;
  assign err_out       = err_r;

endmodule

// File: tb/tb_minibyte_busif.sv
// Bench for minibyte_busif: directed checks of the documented timing plus a
// randomized CPU/device run against a cycle-level behavioural model.
module tb_minibyte_busif;

  localparam int TMO = 8;

  logic       clk_in, rst_in, ena_in;
  logic [7:0] cpu_addr_in, cpu_wdata_in, cpu_rdata_out;
  logic       cpu_we_in, cpu_ena_out;
  logic [7:0] ext_addr_out, ext_data_out, ext_data_in;
  logic       ext_oe_out, ext_we_out, ext_req_out, ext_ack_in;
  logic [7:0] port_in, port_out;
  logic       err_out;

  int         n_tests = 0;
  int         n_fail  = 0;

  // device model: 0 = ack follows req combinationally, 1 = random delays, 2 = never acks
  int         dev_mode = 0;
  int         dev_wait = 0;
  logic       dev_ack_r = 1'b0;
  logic [7:0] dev_data = 8'h00;

  logic       log_ena [64];
  logic       log_req [64];
  logic       log_oe  [64];
  logic [7:0] log_rd  [64];

  // behavioural model state
  logic       m_busy, m_req, m_done, m_we, m_err;
  int         m_age;
  logic [7:0] m_port, m_rd, m_addr, m_data;
  logic       a_h1, a_h2;
  logic [7:0] p_h1, p_h2;

  assign ext_ack_in  = (dev_mode == 0) ? ext_req_out : dev_ack_r;
  assign ext_data_in = dev_data;

  minibyte_busif #(.TIMEOUT(TMO)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .ena_in(ena_in),
    .cpu_addr_in(cpu_addr_in), .cpu_wdata_in(cpu_wdata_in), .cpu_we_in(cpu_we_in),
    .cpu_rdata_out(cpu_rdata_out), .cpu_ena_out(cpu_ena_out),
    .ext_addr_out(ext_addr_out), .ext_data_out(ext_data_out), .ext_data_in(ext_data_in),
    .ext_oe_out(ext_oe_out), .ext_we_out(ext_we_out), .ext_req_out(ext_req_out),
    .ext_ack_in(ext_ack_in), .port_in(port_in), .port_out(port_out), .err_out(err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 8'h%02h, expected 8'h%02h", name, $time, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Device side: in random mode follow req with a random lag, new data on each ack rise
  always @(posedge clk_in) begin
    #1;
    if (dev_mode == 1) begin
      if (ext_req_out != dev_ack_r) begin
        if (dev_wait == 0) begin
          if (!dev_ack_r) dev_data = 8'($urandom);
          dev_ack_r = ext_req_out;
          dev_wait  = $urandom_range(0, 6);
        end else begin
          dev_wait--;
        end
      end
    end else begin
      dev_ack_r = 1'b0;
    end
  end

  // Model and per-cycle comparison, away from the active edge
  always @(negedge clk_in) begin
    logic ack_m;
    logic [7:0] psync_m;
    logic internal_m;
    if (!rst_in) begin
      m_busy = 1'b0; m_req = 1'b0; m_done = 1'b0; m_we = 1'b0; m_err = 1'b0;
      m_age = 0; m_port = 8'h00; m_rd = 8'h00; m_addr = 8'h00; m_data = 8'h00;
      a_h1 = 1'b0; a_h2 = 1'b0; p_h1 = 8'h00; p_h2 = 8'h00;
      check1("reset_cpu_ena", cpu_ena_out, 1'b0);
      check1("reset_req", ext_req_out, 1'b0);
      check("reset_port_out", port_out, 8'h00);
    end else begin
      ack_m      = a_h2;
      psync_m    = p_h2;
      internal_m = (cpu_addr_in == 8'hFF) || (cpu_addr_in == 8'hFE);
      check1("req", ext_req_out, m_req);
      check1("oe", ext_oe_out, m_req & m_we);
      check1("we", ext_we_out, m_we);
      check("ext_addr", ext_addr_out, m_addr);
      check("ext_data", ext_data_out, m_data);
      check("port_out", port_out, m_port);
      check1("err", err_out, m_err);
      if (m_done) begin
        check1("cpu_ena_done", cpu_ena_out, ena_in);
        check("rdata_done", cpu_rdata_out, m_rd);
      end else if (m_busy) begin
        check1("cpu_ena_busy", cpu_ena_out, 1'b0);
      end else if (internal_m) begin
        check1("cpu_ena_internal", cpu_ena_out, ena_in);
        check("rdata_internal", cpu_rdata_out, (cpu_addr_in == 8'hFF) ? m_port : psync_m);
      end else begin
        check1("cpu_ena_ext_idle", cpu_ena_out, 1'b0);
      end
      // advance one cycle
      if (m_done) begin
        if (ena_in) m_done = 1'b0;
      end else if (m_busy) begin
        if (m_age == TMO - 1) begin
          m_rd = 8'hFF; m_err = 1'b1; m_req = 1'b0; m_busy = 1'b0; m_done = 1'b1;
        end else if (m_req && ack_m) begin
          m_req = 1'b0;
          if (!m_we) m_rd = ext_data_in;
        end else if (!m_req && !ack_m) begin
          m_busy = 1'b0; m_done = 1'b1;
        end
        m_age++;
      end else if (ena_in) begin
        if (cpu_addr_in == 8'hFF && cpu_we_in) begin
          m_port = cpu_wdata_in;
        end else if (!internal_m && !ack_m) begin
          m_busy = 1'b1; m_req = 1'b1; m_age = 0;
          m_addr = cpu_addr_in; m_data = cpu_wdata_in; m_we = cpu_we_in;
        end
      end
      a_h2 = a_h1; a_h1 = ext_ack_in;
      p_h2 = p_h1; p_h1 = port_in;
    end
  end

  // One CPU access, called just after a rising edge; logs outputs per cycle from index 0
  task automatic do_access(input logic [7:0] a, input logic [7:0] d, input logic w,
                           input int ena_mode, input int drop, input int resume,
                           output int len);
    logic done;
    cpu_addr_in = a; cpu_wdata_in = d; cpu_we_in = w;
    len = 0; done = 1'b0;
    while (!done && len < 64) begin
      case (ena_mode)
        0:       ena_in = 1'b1;
        1:       ena_in = !(len >= drop && len < resume);
        default: begin
          ena_in = ($urandom_range(0, 4) != 0);
          if ($urandom_range(0, 3) == 0) port_in = 8'($urandom);
        end
      endcase
      @(negedge clk_in);
      log_ena[len] = cpu_ena_out; log_req[len] = ext_req_out;
      log_oe[len]  = ext_oe_out;  log_rd[len]  = cpu_rdata_out;
      done = cpu_ena_out;
      @(posedge clk_in); #1;
      len++;
    end
    check1("access_completes", done, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int len, nreq, sel;
    logic [7:0] a;
    rst_in = 1'b1; ena_in = 1'b1; cpu_addr_in = 8'hFF; cpu_wdata_in = 8'h00;
    cpu_we_in = 1'b0; port_in = 8'h00;
    #2 rst_in = 1'b0;
    @(negedge clk_in); @(negedge clk_in);
    @(posedge clk_in); #1 rst_in = 1'b1;
    @(negedge clk_in);
    check("post_reset_port_out", port_out, 8'h00);
    check1("post_reset_err", err_out, 1'b0);
    check("post_reset_ext_addr", ext_addr_out, 8'h00);
    @(posedge clk_in); #1;

    // internal port pair
    do_access(8'hFF, 8'hA5, 1'b1, 0, 0, 0, len);
    check("int_write_len", 8'(len), 8'd1);
    check("int_write_port_out", port_out, 8'hA5);
    do_access(8'hFF, 8'h00, 1'b0, 0, 0, 0, len);
    check("int_read_data", log_rd[0], 8'hA5);
    do_access(8'hFE, 8'h11, 1'b1, 0, 0, 0, len);
    check("port_in_write_ignored", port_out, 8'hA5);

    // port input synchronizer latency
    cpu_addr_in = 8'hFE; cpu_we_in = 1'b0; port_in = 8'h3C;
    @(posedge clk_in); #1;
    @(negedge clk_in);
    check("port_in_old", cpu_rdata_out, 8'h00);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    check("port_in_new", cpu_rdata_out, 8'h3C);
    @(posedge clk_in); #1;

    // external read, ack = req
    dev_mode = 0; dev_data = 8'h5A;
    do_access(8'h10, 8'h00, 1'b0, 0, 0, 0, len);
    check("ext_read_len", 8'(len), 8'd8);
    for (int i = 0; i < 8; i++) begin
      check1("ext_read_req_window", log_req[i], (i >= 1 && i <= 3));
      check1("ext_read_ena_window", log_ena[i], (i == 7));
    end
    check("ext_read_data", log_rd[7], 8'h5A);

    // external write
    dev_data = 8'h99;
    do_access(8'h20, 8'hC3, 1'b1, 0, 0, 0, len);
    check("ext_write_addr", ext_addr_out, 8'h20);
    check("ext_write_data", ext_data_out, 8'hC3);
    check1("ext_write_we", ext_we_out, 1'b1);
    nreq = 0;
    for (int i = 0; i < len; i++) begin
      check1("ext_write_oe_eq_req", log_oe[i], log_req[i]);
      if (log_req[i]) nreq++;
    end
    check("ext_write_req_cycles", 8'(nreq), 8'd3);

    // watchdog timeout, ack never arrives
    dev_mode = 2;
    do_access(8'h30, 8'h00, 1'b0, 0, 0, 0, len);
    check("timeout_len", 8'(len), 8'd10);
    check1("timeout_stall_last", log_ena[8], 1'b0);
    check1("timeout_complete", log_ena[9], 1'b1);
    check("timeout_rdata", log_rd[9], 8'hFF);
    check1("timeout_err", err_out, 1'b1);

    // enable low through COMPLETE holds the result
    dev_mode = 0; dev_data = 8'h77;
    do_access(8'h50, 8'h00, 1'b0, 1, 3, 12, len);
    check("ena_hold_len", 8'(len), 8'd13);
    for (int i = 7; i < 12; i++) check1("ena_hold_stall", log_ena[i], 1'b0);
    check("ena_hold_rdata", log_rd[12], 8'h77);

    // randomized traffic against the model
    dev_mode = 1;
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 2)      a = 8'hFF;
      else if (sel == 3) a = 8'hFE;
      else               a = 8'($urandom);
      do_access(a, 8'($urandom), 1'($urandom), 2, 0, 0, len);
    end
    check1("err_sticky", err_out, 1'b1);

    // let any outstanding ack drain, then reset in the middle of a request
    ena_in = 1'b1; cpu_addr_in = 8'hFF; cpu_we_in = 1'b0;
    repeat (12) begin @(posedge clk_in); #1; end
    dev_mode = 0;
    repeat (4) begin @(posedge clk_in); #1; end
    cpu_addr_in = 8'h40;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    check1("mid_req_before_reset", ext_req_out, 1'b1);
    #1 rst_in = 1'b0;
    #1;
    check1("async_reset_req", ext_req_out, 1'b0);
    check1("async_reset_oe", ext_oe_out, 1'b0);
    check1("async_reset_cpu_ena", cpu_ena_out, 1'b0);
    check("async_reset_port_out", port_out, 8'h00);
    @(posedge clk_in); #1;
    rst_in = 1'b1; cpu_addr_in = 8'hFF;
    @(negedge clk_in);
    check1("after_reset_idle", cpu_ena_out, 1'b1);
    check1("after_reset_err", err_out, 1'b0);
    check("after_reset_rdata", cpu_rdata_out, 8'h00);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/minibyte_busif.md
# minibyte_busif

Bus interface between the minibyte_cpu memory port and the chip pins. It decodes each CPU access. Two top-of-map addresses hit an internal 8-bit I/O port pair. Every other address becomes a four-phase req/ack transaction on an external byte bus, and the CPU is stalled through its enable input until the transaction completes. A watchdog ends hung transactions and sets a sticky error flag.

## Interface
- TIMEOUT, 64: cycles spent in REQ/RELEASE before forced completion (2..255).
- clk_in  in  1  system clock; all state updates on the rising edge.
- rst_in  in  1  asynchronous active-low reset.
- ena_in  in  1  global enable from the top level.
- cpu_addr_in  in  8  CPU addr_out.
- cpu_wdata_in  in  8  CPU data_out.
- cpu_we_in  in  1  CPU we_out; 1 = write.
- cpu_rdata_out  out  8  to CPU data_in.
- cpu_ena_out  out  1  to CPU ena_in; 0 stalls the CPU.
- ext_addr_out  out  8  latched external address.
- ext_data_out  out  8  latched write data.
- ext_data_in  in  8  external read data; valid while ext_ack_in = 1.
- ext_oe_out  out  1  pad output enable for ext_data_out.
- ext_we_out  out  1  latched write flag.
- ext_req_out  out  1  request (four-phase).
- ext_ack_in  in  1  acknowledge; asynchronous.
- port_in  in  8  general input pins; asynchronous.
- port_out  out  8  output port register.
- err_out  out  1  sticky timeout flag.

## Operation
- Decode in IDLE:
  - 8'hFF is PORT_OUT, read/write.
  - 8'hFE is PORT_IN, read-only; writes are ignored.
  - All other addresses are external.
- Internal hit in IDLE:
  - cpu_ena_out = ena_in, no stall.
  - A write updates port_out at the edge where cpu_ena_out = 1.
  - A read returns port_out or the synchronized port_in combinationally.
- External hit in IDLE with ena_in = 1:
  - cpu_ena_out = 0.
  - Address, wdata and we are latched; go to REQ.
- States:
  - IDLE.
  - REQ: req = 1; oe = we_latched.
  - RELEASE: req = 0.
  - COMPLETE: cpu_ena_out = ena_in; cpu_rdata_out = rd_latch.
- Transitions:
  - REQ → RELEASE when ack_s = 1; ext_data_in is captured into rd_latch if the access is a read.
  - RELEASE → COMPLETE when ack_s = 0.
  - COMPLETE → IDLE when ena_in = 1; otherwise hold in COMPLETE.
- ack_s is ext_ack_in after the 2-flop synchronizer. port_in uses the same 2-flop synchronizer, per bit.
- Watchdog:
  - 8-bit counter cleared in IDLE and incremented in REQ and RELEASE.
  - When the count reaches TIMEOUT−1: rd_latch = 8'hFF, err_out set, go to COMPLETE.
  - A late ack after a timeout is ignored. The next request waits in IDLE until ack_s = 0.
- err_out is cleared only by reset.
- ena_in = 0:
  - No new transaction starts.
  - An in-flight transaction proceeds up to COMPLETE and holds there.

## Timing
- Reset values:
  - State IDLE.
  - ext_req_out, ext_oe_out, ext_we_out, err_out = 0.
  - port_out, ext_addr_out, ext_data_out, rd_latch = 8'h00.
  - Synchronizer flops = 0.
  - cpu_ena_out = 0 while rst_in = 0.
- Reset mid-transaction drops req and oe immediately (asynchronous).
- All ext_* outputs are registered. cpu_ena_out and cpu_rdata_out are combinational from state, decode and ena_in.
- With the external device modelled as ack = req, same cycle, and the access detected in cycle N:
  - req is high in cycles N+1..N+3.
  - RELEASE runs N+4..N+6.
  - COMPLETE is cycle N+7.
  - cpu_ena_out is low in N..N+6.
- Minimum stall is 7 cycles.
- The device must hold ext_data_in stable from raising ack until it sees req = 0.

## Structure
- Shared package minibyte_pkg holds:
  - the busif state enum (IDLE, REQ, RELEASE, COMPLETE);
  - ADDR_PORT_OUT = 8'hFF and ADDR_PORT_IN = 8'hFE;
  - TIMEOUT_RDATA = 8'hFF.
- Sub-module minibyte_sync2: parameterized-width 2-flop synchronizer with async active-low reset. It is instantiated for ext_ack_in (width 1) and port_in (width 8).

## Test plan
- Internal write/read:
  - Write 8'hA5 to 8'hFF → port_out = 8'hA5 after that edge, no stall.
  - Read 8'hFF → 8'hA5.
  - Write to 8'hFE → port_out unchanged.
- Port input: drive port_in = 8'h3C, wait 2 cycles, read 8'hFE → 8'h3C. Reading in the first cycle after the change returns the old value.
- External read:
  - Address 8'h10, device ack = req, ext_data_in = 8'h5A.
  - Expect req high N+1..N+3, cpu_ena_out low N..N+6, COMPLETE at N+7 with cpu_rdata_out = 8'h5A.
- External write:
  - Address 8'h20, data 8'hC3.
  - Expect ext_addr_out = 8'h20, ext_data_out = 8'hC3, ext_we_out = 1, ext_oe_out = 1 exactly while req = 1.
- Timeout, TIMEOUT = 8, ack tied low:
  - COMPLETE is reached 8 cycles after entering REQ, with cpu_rdata_out = 8'hFF and err_out = 1.
  - err_out stays 1 until reset.
- Reset and enable:
  - Drop rst_in during REQ → req = 0 immediately, state IDLE, port_out = 8'h00.
  - Hold ena_in = 0 through COMPLETE → state holds and cpu_ena_out = 0 until ena_in returns.
